// File: rtl/mul_32_32_64.sv
// rtl/mul_32_32_64.sv - 32x32->64 sequential shift-add multiplier, signed or unsigned.
module mul_32_32_64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] prod
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_mag_q, a_mag_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        neg_q, neg_d;
  logic [63:0] prod_q, prod_d;
  logic        done_q, done_d;

  logic [31:0] a_mag_in;
  logic [31:0] b_mag_in;
  logic [32:0] sum;
  logic [63:0] acc;

  // 0x80000000 negates to itself, which read unsigned is exactly 2^31.
  always_comb begin
    a_mag_in = (sign && a[31]) ? (~a + 32'd1) : a;
    b_mag_in = (sign && b[31]) ? (~b + 32'd1) : b;
    sum      = {1'b0, hi_q} + {1'b0, (lo_q[0] ? a_mag_q : 32'd0)};
    acc      = {hi_q, lo_q};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_mag_d = a_mag_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    neg_d   = neg_q;
    prod_d  = prod_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_mag_d = a_mag_in;
          hi_d    = 32'd0;
          lo_d    = b_mag_in;
          neg_d   = sign & (a[31] ^ b[31]);
          cnt_d   = 5'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Add-then-shift: carry enters hi[31], sum LSB moves into lo[31].
        hi_d  = sum[32:1];
        lo_d  = {sum[0], lo_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = FIX;
        end
      end
      FIX: begin
        prod_d  = neg_q ? (~acc + 64'd1) : acc;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      a_mag_q <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      neg_q   <= 1'b0;
      prod_q  <= 64'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_mag_q <= a_mag_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      neg_q   <= neg_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == CALC) || (state_q == FIX);
  assign done = done_q;
  assign prod = prod_q;

endmodule
